// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet demultiplexer:
// header field defaults, drop-reason codes, FSM state encoding and a
// saturating counter helper.
package axis_pkg;

    localparam logic [15:0]  MAGIC_DEFAULT       = 16'hB6CF;
    localparam int unsigned  MAGIC_LSB           = 16;
    localparam int unsigned  MAGIC_WIDTH         = 16;
    localparam int unsigned  INDEX_START_DEFAULT = 10;
    localparam int unsigned  INDEX_WIDTH_DEFAULT = 5;
    localparam int unsigned  DEST_SHIFT_DEFAULT  = 2;
    localparam int unsigned  COUNT_WIDTH         = 16;
    localparam int unsigned  DROP_CODE_WIDTH     = 2;

    typedef enum logic [DROP_CODE_WIDTH-1:0] {
        DROP_NONE      = 2'b00,
        DROP_BAD_MAGIC = 2'b01,
        DROP_BAD_DEST  = 2'b10
    } drop_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_DROP = 2'b10
    } demux_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == {COUNT_WIDTH{1'b1}}) ? v : v + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/axis_demux_if.sv
// AXI-Stream bundle with LANES parallel lanes sharing one flattened bus.
// Lane k occupies tdata[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH] (tuser likewise).
//   tvalid/tready/tlast : LANES bits, per-lane handshake
//   tdata               : LANES*DATA_WIDTH
//   tuser               : LANES*USER_WIDTH
// master drives payload/valid, slave drives ready.
interface axis_demux_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned LANES      = 1
) ();

    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES-1:0]            tlast;
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES*USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tlast,
        output tready
    );

endinterface

// File: rtl/axis_out_stage.sv
// Single-entry output holding register shared by all sinks.
//   clk, rst            : clock, synchronous active-high reset (flushes entry)
//   load, load_*        : write a beat and its destination sink
//   m_tready            : per-sink ready
//   can_load_c          : entry empty or draining this cycle
//   m_tvalid/m_tlast/m_tdata/m_tuser : per-sink outputs decoded from the entry
module axis_out_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned NUM_SINKS  = 4,
    parameter int unsigned DEST_W     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [DEST_W-1:0]              load_dest,
    input  logic [DATA_WIDTH-1:0]          load_data,
    input  logic [USER_WIDTH-1:0]          load_user,
    input  logic                           load_last,
    input  logic [NUM_SINKS-1:0]           m_tready,
    output logic                           can_load_c,
    output logic [NUM_SINKS-1:0]           m_tvalid,
    output logic [NUM_SINKS-1:0]           m_tlast,
    output logic [NUM_SINKS*DATA_WIDTH-1:0] m_tdata,
    output logic [NUM_SINKS*USER_WIDTH-1:0] m_tuser
);

    logic                  valid_q;
    logic [DEST_W-1:0]     dest_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  last_q;

    // Holding register: load has priority, otherwise empty on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            dest_q  <= load_dest;
            data_q  <= load_data;
            user_q  <= load_user;
            last_q  <= load_last;
        end else if (valid_q && m_tready[dest_q]) begin
            valid_q <= 1'b0;
        end
    end

    assign can_load_c = !valid_q || m_tready[dest_q];

    // Every lane sees the same payload; only the addressed lane is valid.
    always_comb begin
        m_tvalid = '0;
        m_tlast  = '0;
        m_tdata  = '0;
        m_tuser  = '0;
        for (int unsigned k = 0; k < NUM_SINKS; k++) begin
            m_tvalid[k]                          = valid_q && (dest_q == DEST_W'(k));
            m_tlast[k]                           = last_q;
            m_tdata[k*DATA_WIDTH +: DATA_WIDTH]  = data_q;
            m_tuser[k*USER_WIDTH +: USER_WIDTH]  = user_q;
        end
    end

endmodule

// File: rtl/axis_demux.sv
// Packet demultiplexer: routes each header-led packet on s_axis to one of
// NUM_SINKS lanes of m_axis, chosen by the header index field. Packets with
// a bad magic or out-of-range destination are discarded and counted.
//   clk, rst   : clock, synchronous active-high reset
//   s_axis     : input stream (single lane)
//   m_axis     : output streams (NUM_SINKS lanes, flattened)
//   dropStrobe : one-cycle pulse per discarded packet
//   dropCode   : drop reason, valid with dropStrobe
//   fwdCount   : packets forwarded (saturating)
//   dropCount  : packets dropped (saturating)
module axis_demux
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned NUM_SINKS       = 4,
    parameter logic [15:0] MAGIC           = MAGIC_DEFAULT,
    parameter int unsigned INDEX_START_BIT = INDEX_START_DEFAULT,
    parameter int unsigned INDEX_WIDTH     = INDEX_WIDTH_DEFAULT,
    parameter int unsigned DEST_SHIFT      = DEST_SHIFT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_demux_if.slave                s_axis,
    axis_demux_if.master               m_axis,
    output logic                       dropStrobe,
    output logic [DROP_CODE_WIDTH-1:0] dropCode,
    output logic [COUNT_WIDTH-1:0]     fwdCount,
    output logic [COUNT_WIDTH-1:0]     dropCount
);

    localparam int unsigned DEST_W = $clog2(NUM_SINKS);

    demux_state_e state_q, state_nxt;
    logic [DEST_W-1:0] cur_dest_q, cur_dest_nxt;
    logic              drop_strobe_nxt;
    drop_code_e        drop_code_nxt;
    logic              fwd_inc, drop_inc;

    logic                   can_load_c;
    logic                   s_ready_c;
    logic                   accept_c;
    logic                   load_c;
    logic [DEST_W-1:0]      load_dest_c;

    logic [MAGIC_WIDTH-1:0] hdr_magic;
    logic [INDEX_WIDTH-1:0] hdr_index;
    logic [INDEX_WIDTH-1:0] hdr_dest_full;
    logic                   hdr_dest_bad;
    logic [DEST_W-1:0]      hdr_dest;

    // Header decode, meaningful only on a header beat.
    assign hdr_magic     = s_axis.tdata[MAGIC_LSB +: MAGIC_WIDTH];
    assign hdr_index     = s_axis.tdata[INDEX_START_BIT +: INDEX_WIDTH];
    assign hdr_dest_full = hdr_index >> DEST_SHIFT;
    assign hdr_dest_bad  = 32'(hdr_dest_full) >= NUM_SINKS;
    assign hdr_dest      = DEST_W'(hdr_dest_full);

    // Ready: follows the holding register except while discarding.
    always_comb begin
        s_ready_c = 1'b0;
        if (!rst) begin
            s_ready_c = (state_q == ST_DROP) ? 1'b1 : can_load_c;
        end
    end

    assign s_axis.tready = s_ready_c;
    assign accept_c      = s_axis.tvalid && s_ready_c;

    // Next-state and per-beat actions.
    always_comb begin
        state_nxt       = state_q;
        cur_dest_nxt    = cur_dest_q;
        load_c          = 1'b0;
        load_dest_c     = cur_dest_q;
        drop_strobe_nxt = 1'b0;
        drop_code_nxt   = DROP_NONE;
        fwd_inc         = 1'b0;
        drop_inc        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (hdr_magic != MAGIC) begin
                        drop_strobe_nxt = 1'b1;
                        drop_code_nxt   = DROP_BAD_MAGIC;
                        drop_inc        = 1'b1;
                        if (!s_axis.tlast) state_nxt = ST_DROP;
                    end else if (hdr_dest_bad) begin
                        drop_strobe_nxt = 1'b1;
                        drop_code_nxt   = DROP_BAD_DEST;
                        drop_inc        = 1'b1;
                        if (!s_axis.tlast) state_nxt = ST_DROP;
                    end else begin
                        load_c       = 1'b1;
                        load_dest_c  = hdr_dest;
                        cur_dest_nxt = hdr_dest;
                        fwd_inc      = 1'b1;
                        if (!s_axis.tlast) state_nxt = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (accept_c) begin
                    load_c = 1'b1;
                    if (s_axis.tlast) state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept_c && s_axis.tlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, drop report and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_dest_q <= '0;
            dropStrobe <= 1'b0;
            dropCode   <= DROP_NONE;
            fwdCount   <= '0;
            dropCount  <= '0;
        end else begin
            state_q    <= state_nxt;
            cur_dest_q <= cur_dest_nxt;
            dropStrobe <= drop_strobe_nxt;
            dropCode   <= drop_code_nxt;
            if (fwd_inc)  fwdCount  <= sat_inc(fwdCount);
            if (drop_inc) dropCount <= sat_inc(dropCount);
        end
    end

    axis_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .NUM_SINKS  (NUM_SINKS),
        .DEST_W     (DEST_W)
    ) u_out_stage (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .load_dest  (load_dest_c),
        .load_data  (s_axis.tdata),
        .load_user  (s_axis.tuser),
        .load_last  (s_axis.tlast),
        .m_tready   (m_axis.tready),
        .can_load_c (can_load_c),
        .m_tvalid   (m_axis.tvalid),
        .m_tlast    (m_axis.tlast),
        .m_tdata    (m_axis.tdata),
        .m_tuser    (m_axis.tuser)
    );

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: routing, drops, backpressure,
// back-to-back packets and mid-packet reset.
module tb_axis_demux;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       dropStrobe;
    logic [1:0] dropCode;
    logic [15:0] fwdCount;
    logic [15:0] dropCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_demux_if #(.DATA_WIDTH(DW), .USER_WIDTH(1), .LANES(1))  s_if ();
    axis_demux_if #(.DATA_WIDTH(DW), .USER_WIDTH(1), .LANES(NS)) m_if ();

    axis_demux dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .dropStrobe (dropStrobe),
        .dropCode   (dropCode),
        .fwdCount   (fwdCount),
        .dropCount  (dropCount)
    );

    function automatic logic [31:0] hdr(input int idx);
        return 32'hB6CF_0000 | 32'(idx << 10);
    endfunction

    function automatic logic [31:0] lane(input int k);
        return m_if.tdata[k*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic u);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
    endtask

    logic [31:0] beats [8];
    logic [3:0]  sinks [8];

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        m_if.tready = 4'b1111;

        // Reset state
        step();
        check("rst_tready",  64'(s_if.tready), 64'h0);
        check("rst_mvalid",  64'(m_if.tvalid), 64'h0);
        check("rst_mlast",   64'(m_if.tlast),  64'h0);
        check("rst_mdata",   64'(m_if.tdata[63:0]), 64'h0);
        check("rst_counts",  64'({fwdCount, dropCount}), 64'h0);
        check("rst_drop",    64'({dropStrobe, dropCode}), 64'h0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_tready", 64'(s_if.tready), 64'h1);

        // Four 2-beat packets, indices 0,4,8,12 -> sinks 0..3
        beats[0] = hdr(0);  beats[1] = 32'hD000_0000;
        beats[2] = hdr(4);  beats[3] = 32'hD000_0001;
        beats[4] = hdr(8);  beats[5] = 32'hD000_0002;
        beats[6] = hdr(12); beats[7] = 32'hD000_0003;
        sinks[0] = 4'b0001; sinks[1] = 4'b0001;
        sinks[2] = 4'b0010; sinks[3] = 4'b0010;
        sinks[4] = 4'b0100; sinks[5] = 4'b0100;
        sinks[6] = 4'b1000; sinks[7] = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, beats[i], 1'(i % 2), 1'(i % 2 == 0));
            step();
            check($sformatf("route_valid_%0d", i), 64'(m_if.tvalid), 64'(sinks[i]));
            check($sformatf("route_data_%0d", i),  64'(lane(i / 2)), 64'(beats[i]));
            check($sformatf("route_last_%0d", i),  64'(m_if.tlast[i / 2]), 64'(i % 2));
            check($sformatf("route_user_%0d", i),  64'(m_if.tuser[i / 2]), 64'(i % 2 == 0));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("route_drained", 64'(m_if.tvalid), 64'h0);
        check("route_fwdcnt",  64'(fwdCount), 64'd4);

        // Bad magic, then a good packet with index 5 -> sink 1
        drive(1'b1, 32'hCACA_0000, 1'b0, 1'b0);
        step();
        check("magic_strobe", 64'(dropStrobe), 64'h1);
        check("magic_code",   64'(dropCode), 64'h1);
        check("magic_dcnt",   64'(dropCount), 64'd1);
        check("magic_nofwd",  64'(m_if.tvalid), 64'h0);
        drive(1'b1, 32'h1111_2222, 1'b1, 1'b0);
        step();
        check("magic_body_strobe", 64'(dropStrobe), 64'h0);
        check("magic_body_nofwd",  64'(m_if.tvalid), 64'h0);
        drive(1'b1, hdr(5), 1'b0, 1'b0);
        step();
        check("good5_valid", 64'(m_if.tvalid), 64'b0010);
        check("good5_hdr",   64'(lane(1)), 64'(hdr(5)));
        drive(1'b1, 32'h5555_0001, 1'b1, 1'b0);
        step();
        check("good5_body", 64'(lane(1)), 64'h5555_0001);
        check("good5_last", 64'(m_if.tlast[1]), 64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("good5_fwdcnt", 64'(fwdCount), 64'd5);

        // Index 16 -> dest 4 out of range
        drive(1'b1, hdr(16), 1'b0, 1'b0);
        step();
        check("dest_strobe", 64'(dropStrobe), 64'h1);
        check("dest_code",   64'(dropCode), 64'h2);
        check("dest_dcnt",   64'(dropCount), 64'd2);
        drive(1'b1, 32'h7777_0000, 1'b1, 1'b0);
        #1;
        check("dest_body_ready", 64'(s_if.tready), 64'h1);
        step();
        check("dest_body_nofwd", 64'(m_if.tvalid), 64'h0);
        check("dest_strobe_off", 64'(dropStrobe), 64'h0);

        // Sink 2 stalls for 10 cycles mid-packet
        m_if.tready = 4'b1011;
        drive(1'b1, hdr(8), 1'b0, 1'b0);
        step();
        check("stall_hdr_valid", 64'(m_if.tvalid), 64'b0100);
        drive(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
        #1;
        check("stall_tready_low", 64'(s_if.tready), 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall_hold_%0d", i), 64'({m_if.tvalid, lane(2)}), 64'({4'b0100, hdr(8)}));
        end
        m_if.tready = 4'b1111;
        #1;
        check("stall_tready_back", 64'(s_if.tready), 64'h1);
        step();
        check("stall_b1", 64'({m_if.tvalid, lane(2)}), 64'({4'b0100, 32'hBEEF_0001}));
        drive(1'b1, 32'hBEEF_0002, 1'b1, 1'b0);
        step();
        check("stall_b2",   64'({m_if.tvalid, lane(2)}), 64'({4'b0100, 32'hBEEF_0002}));
        check("stall_last", 64'(m_if.tlast[2]), 64'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("stall_drained", 64'(m_if.tvalid), 64'h0);
        check("stall_fwdcnt",  64'(fwdCount), 64'd6);

        // Back-to-back: sink 3 then sink 0, no bubble
        drive(1'b1, hdr(12), 1'b0, 1'b0);
        step();
        check("b2b_0", 64'({m_if.tvalid, lane(3)}), 64'({4'b1000, hdr(12)}));
        drive(1'b1, 32'hC3C3_0001, 1'b1, 1'b0);
        step();
        check("b2b_1", 64'({m_if.tvalid, lane(3)}), 64'({4'b1000, 32'hC3C3_0001}));
        drive(1'b1, hdr(1), 1'b0, 1'b0);
        #1;
        check("b2b_ready", 64'(s_if.tready), 64'h1);
        step();
        check("b2b_2", 64'({m_if.tvalid, lane(0)}), 64'({4'b0001, hdr(1)}));
        drive(1'b1, 32'hC0C0_0001, 1'b1, 1'b0);
        step();
        check("b2b_3", 64'({m_if.tvalid, lane(0)}), 64'({4'b0001, 32'hC0C0_0001}));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("b2b_fwdcnt", 64'(fwdCount), 64'd8);

        // Reset in the middle of a forwarded packet
        drive(1'b1, hdr(4), 1'b0, 1'b0);
        step();
        check("mrst_pre", 64'(m_if.tvalid), 64'b0010);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        m_if.tready = 4'b0000;
        rst = 1'b1;
        step();
        check("mrst_valid",  64'(m_if.tvalid), 64'h0);
        check("mrst_counts", 64'({fwdCount, dropCount}), 64'h0);
        rst = 1'b0;
        m_if.tready = 4'b1111;
        // Remainder of the interrupted packet is parsed as a header
        drive(1'b1, 32'hD000_0099, 1'b1, 1'b0);
        step();
        check("mrst_remainder", 64'({dropStrobe, dropCode}), 64'({1'b1, 2'b01}));
        drive(1'b1, hdr(9), 1'b0, 1'b0);
        step();
        check("mrst_new_hdr", 64'({m_if.tvalid, lane(2)}), 64'({4'b0100, hdr(9)}));
        drive(1'b1, 32'h9999_0001, 1'b1, 1'b0);
        step();
        check("mrst_new_body", 64'({m_if.tvalid, lane(2)}), 64'({4'b0100, 32'h9999_0001}));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("mrst_counts_after", 64'({fwdCount, dropCount}), 64'({16'd1, 16'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
